// File: rtl/score_pkg.sv
// Shared types and helpers for the scoreboard score register block.
package score_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_UNDO = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        REJ_NONE    = 2'b00,
        REJ_UNDER   = 2'b01,
        REJ_OVER    = 2'b10,
        REJ_INVALID = 2'b11
    } rej_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CHECK = 2'b01,
        S_APPLY = 2'b10
    } state_e;

    localparam int PTS_W = 2;

    // One spare bit so score + points cannot wrap before the range check.
    function automatic int sum_width(input int score_w);
        return score_w + 1;
    endfunction

endpackage

// File: rtl/score_guard.sv
// Combinational legality check and next-score arithmetic for one ADD/SUB.
// UNDO and team-range checks are resolved by the caller.
module score_guard
    import score_pkg::*;
#(
    parameter int SCORE_W   = 7,
    parameter int MAX_SCORE = 99
) (
    input  logic [SCORE_W-1:0] cur,
    input  op_e                op,
    input  logic [PTS_W-1:0]   pts,
    output logic [SCORE_W-1:0] next,
    output logic               legal,
    output rej_e               code
);

    localparam int SUM_W = sum_width(SCORE_W);

    logic [SUM_W-1:0] cur_ext;
    logic [SUM_W-1:0] pts_ext;
    logic [SUM_W-1:0] sum;

    // Range-check the requested change and compute the resulting score.
    always_comb begin
        cur_ext = {1'b0, cur};
        pts_ext = SUM_W'(pts);
        sum     = cur_ext + pts_ext;
        next    = cur;
        legal   = 1'b0;
        code    = REJ_INVALID;
        if (pts != '0) begin
            case (op)
                OP_ADD: begin
                    if (sum <= SUM_W'(MAX_SCORE)) begin
                        next  = sum[SCORE_W-1:0];
                        legal = 1'b1;
                        code  = REJ_NONE;
                    end else begin
                        code = REJ_OVER;
                    end
                end
                OP_SUB: begin
                    if (pts_ext <= cur_ext) begin
                        next  = cur - SCORE_W'(pts);
                        legal = 1'b1;
                        code  = REJ_NONE;
                    end else begin
                        code = REJ_UNDER;
                    end
                end
                default: code = REJ_INVALID;
            endcase
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Multi-team score register: accepts one scoring command at a time, checks it,
// commits or rejects it, keeps a one-deep undo history and reports leader/tie.
module score_keeper
    import score_pkg::*;
#(
    parameter int N_TEAMS   = 2,
    parameter int SCORE_W   = 7,
    parameter int MAX_SCORE = 99,
    parameter int TEAM_W    = $clog2(N_TEAMS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [TEAM_W-1:0]            cmd_team,
    input  logic [1:0]                   cmd_pts,
    output logic [N_TEAMS*SCORE_W-1:0]   score,
    output logic                         done,
    output logic                         rej,
    output logic [1:0]                   rej_code,
    output logic [TEAM_W-1:0]            leader,
    output logic                         tie
);

    state_e state_q, state_d;
    logic   accept;

    // Latched command
    op_e                op_p0;
    logic [TEAM_W-1:0]  team_p0;
    logic [PTS_W-1:0]   pts_p0;

    // Verdict registered in CHECK
    logic [TEAM_W-1:0]  team_p1;
    logic [SCORE_W-1:0] next_p1;
    logic [SCORE_W-1:0] prev_p1;
    logic               legal_p1;
    rej_e               code_p1;
    logic               undo_p1;

    logic [SCORE_W-1:0] scores [N_TEAMS];
    logic               hist_valid;
    logic [TEAM_W-1:0]  hist_team;
    logic [SCORE_W-1:0] hist_score;

    logic [SCORE_W-1:0] cur_score;
    logic               team_ok;
    logic [SCORE_W-1:0] g_next;
    logic               g_legal;
    rej_e               g_code;

    logic [TEAM_W-1:0]  v_team;
    logic [SCORE_W-1:0] v_next;
    logic               v_legal;
    rej_e               v_code;

    logic [SCORE_W-1:0] best;
    logic [TEAM_W-1:0]  lead_d;
    logic               seen_top;
    logic               tie_d;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and handshake; clear forces IDLE and blocks acceptance
    always_comb begin
        state_d   = state_q;
        cmd_ready = (state_q == S_IDLE);
        accept    = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        accept  = 1'b1;
                        state_d = S_CHECK;
                    end
                end
                S_CHECK: state_d = S_APPLY;
                S_APPLY: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Capture the command on the accepting handshake
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0   <= op_e'(cmd_op);
            team_p0 <= cmd_team;
            pts_p0  <= cmd_pts;
        end
    end

    // Select the target team's current score; flag out-of-range indices
    always_comb begin
        cur_score = '0;
        team_ok   = 1'b0;
        for (int i = 0; i < N_TEAMS; i++) begin
            if (team_p0 == TEAM_W'(i)) begin
                cur_score = scores[i];
                team_ok   = 1'b1;
            end
        end
    end

    score_guard #(
        .SCORE_W   (SCORE_W),
        .MAX_SCORE (MAX_SCORE)
    ) u_guard (
        .cur   (cur_score),
        .op    (op_p0),
        .pts   (pts_p0),
        .next  (g_next),
        .legal (g_legal),
        .code  (g_code)
    );

    // Merge guard verdict with team-range and undo-history checks
    always_comb begin
        v_team  = team_p0;
        v_next  = g_next;
        v_legal = g_legal && team_ok;
        v_code  = team_ok ? g_code : REJ_INVALID;
        if (op_p0 == OP_UNDO) begin
            v_team  = hist_team;
            v_next  = hist_score;
            v_legal = hist_valid;
            v_code  = hist_valid ? REJ_NONE : REJ_INVALID;
        end
    end

    // CHECK stage: register the selected score, result and verdict
    always_ff @(posedge clk) begin
        if (state_q == S_CHECK) begin
            team_p1  <= v_team;
            next_p1  <= v_next;
            prev_p1  <= cur_score;
            legal_p1 <= v_legal;
            code_p1  <= v_code;
            undo_p1  <= (op_p0 == OP_UNDO);
        end
    end

    // APPLY stage: commit scores and history, report completion status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TEAMS; i++) scores[i] <= '0;
            hist_valid <= 1'b0;
            done       <= 1'b0;
            rej        <= 1'b0;
            rej_code   <= REJ_NONE;
        end else if (clear) begin
            for (int i = 0; i < N_TEAMS; i++) scores[i] <= '0;
            hist_valid <= 1'b0;
            done       <= 1'b0;
            rej        <= 1'b0;
        end else begin
            done <= 1'b0;
            rej  <= 1'b0;
            if (state_q == S_APPLY) begin
                done     <= 1'b1;
                rej      <= !legal_p1;
                rej_code <= code_p1;
                if (legal_p1) begin
                    for (int i = 0; i < N_TEAMS; i++) begin
                        if (team_p1 == TEAM_W'(i)) scores[i] <= next_p1;
                    end
                    if (undo_p1) begin
                        hist_valid <= 1'b0;
                    end else begin
                        hist_valid <= 1'b1;
                        hist_team  <= team_p1;
                        hist_score <= prev_p1;
                    end
                end
            end
        end
    end

    // Pack per-team scores, team 0 in the LSBs
    always_comb begin
        score = '0;
        for (int i = 0; i < N_TEAMS; i++) score[i*SCORE_W +: SCORE_W] = scores[i];
    end

    // Linear scan for the top score; strict '>' keeps the lowest index on ties
    always_comb begin
        best     = scores[0];
        lead_d   = '0;
        seen_top = 1'b0;
        tie_d    = 1'b0;
        for (int i = 1; i < N_TEAMS; i++) begin
            if (scores[i] > best) begin
                best   = scores[i];
                lead_d = TEAM_W'(i);
            end
        end
        for (int i = 0; i < N_TEAMS; i++) begin
            if (scores[i] == best) begin
                if (seen_top) tie_d = 1'b1;
                seen_top = 1'b1;
            end
        end
    end

    // Leader/tie registered one cycle behind the score register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            leader <= '0;
            tie    <= 1'b1;
        end else begin
            leader <= lead_d;
            tie    <= tie_d;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a 2-team default instance and a 4-team
// 8-bit instance. Stimulus pushes expected responses; monitors pop on done.
module tb_score_keeper;

    localparam logic [1:0] ADD  = 2'b00;
    localparam logic [1:0] SUB  = 2'b01;
    localparam logic [1:0] UNDO = 2'b10;
    localparam logic [1:0] RSV  = 2'b11;

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_UNDER = 2'b01;
    localparam logic [1:0] C_OVER  = 2'b10;
    localparam logic [1:0] C_INV   = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       clr_a, clr_b, vld_a, vld_b;
    logic [1:0] op, pts, team;

    logic        rdy_a, done_a, rej_a, tie_a;
    logic [1:0]  rej_code_a;
    logic [13:0] score_a;
    logic [0:0]  leader_a;

    logic        rdy_b, done_b, rej_b, tie_b;
    logic [1:0]  rej_code_b;
    logic [31:0] score_b;
    logic [1:0]  leader_b;

    score_keeper u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clr_a),
        .cmd_valid (vld_a),
        .cmd_ready (rdy_a),
        .cmd_op    (op),
        .cmd_team  (team[0:0]),
        .cmd_pts   (pts),
        .score     (score_a),
        .done      (done_a),
        .rej       (rej_a),
        .rej_code  (rej_code_a),
        .leader    (leader_a),
        .tie       (tie_a)
    );

    score_keeper #(
        .N_TEAMS   (4),
        .SCORE_W   (8),
        .MAX_SCORE (200)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clr_b),
        .cmd_valid (vld_b),
        .cmd_ready (rdy_b),
        .cmd_op    (op),
        .cmd_team  (team),
        .cmd_pts   (pts),
        .score     (score_b),
        .done      (done_b),
        .rej       (rej_b),
        .rej_code  (rej_code_b),
        .leader    (leader_b),
        .tie       (tie_b)
    );

    typedef struct {
        int          cyc;
        logic        rej;
        logic [1:0]  code;
        logic [31:0] score;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h), cycle %0d",
                     nm, act, act, req, req, cyc);
        end
    endtask

    function automatic logic [31:0] pa(input int t0, input int t1);
        return 32'(t0) | (32'(t1) << 7);
    endfunction

    function automatic logic [31:0] pb(input int t0, input int t1, input int t2, input int t3);
        return 32'(t0) | (32'(t1) << 8) | (32'(t2) << 16) | (32'(t3) << 24);
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue one command to DUT b (1) or a (0) and queue its expected response
    task automatic send(input bit b, input logic [1:0] o, input int tm, input logic [1:0] p,
                        input logic erej, input logic [1:0] ecode, input logic [31:0] esc);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!(b ? rdy_b : rdy_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            n_vec++;
            n_bad++;
            $display("FAIL ready_timeout: dut %0d never ready, cycle %0d", b, cyc);
            return;
        end
        op   = o;
        team = 2'(tm);
        pts  = p;
        if (b) vld_b = 1'b1;
        else   vld_a = 1'b1;
        @(posedge clk);
        #1;
        vld_a   = 1'b0;
        vld_b   = 1'b0;
        e.cyc   = cyc + 2;
        e.rej   = erej;
        e.code  = ecode;
        e.score = esc;
        if (b) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    task automatic clear_a();
        @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
    endtask

    // Monitor for DUT a
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_n && done_a) begin
            if (qa.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done_a: got done=1, expected none, cycle %0d", cyc);
            end else begin
                e = qa.pop_front();
                cmp("done_cycle_a", 32'(cyc), 32'(e.cyc));
                cmp("rej_a", 32'(rej_a), 32'(e.rej));
                cmp("rej_code_a", 32'(rej_code_a), 32'(e.code));
                cmp("score_a", 32'(score_a), e.score);
            end
        end
    end

    // Monitor for DUT b
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_n && done_b) begin
            if (qb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done_b: got done=1, expected none, cycle %0d", cyc);
            end else begin
                e = qb.pop_front();
                cmp("done_cycle_b", 32'(cyc), 32'(e.cyc));
                cmp("rej_b", 32'(rej_b), 32'(e.rej));
                cmp("rej_code_b", 32'(rej_code_b), 32'(e.code));
                cmp("score_b", score_b, e.score);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        vld_a = 1'b0;
        vld_b = 1'b0;
        op    = ADD;
        team  = 2'd0;
        pts   = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("rst_score_a", 32'(score_a), 0);
        cmp("rst_ready_a", 32'(rdy_a), 1);
        cmp("rst_done_a", 32'(done_a), 0);
        cmp("rst_rej_a", 32'(rej_a), 0);
        cmp("rst_rej_code_a", 32'(rej_code_a), 0);
        cmp("rst_leader_a", 32'(leader_a), 0);
        cmp("rst_tie_a", 32'(tie_a), 1);
        cmp("rst_score_b", score_b, 0);
        cmp("rst_tie_b", 32'(tie_b), 1);
        rst_n = 1'b1;

        // Basic adds
        send(0, ADD, 0, 2'd3, 0, C_NONE, pa(3, 0));
        send(0, ADD, 0, 2'd3, 0, C_NONE, pa(6, 0));
        send(0, ADD, 1, 2'd2, 0, C_NONE, pa(6, 2));
        settle(5);
        cmp("leader_6_2", 32'(leader_a), 0);
        cmp("tie_6_2", 32'(tie_a), 0);

        // Underflow, and a rejected command keeps the undo history
        clear_a();
        cmp("score_after_clear", 32'(score_a), 0);
        settle(2);
        cmp("tie_after_clear", 32'(tie_a), 1);
        send(0, ADD,  0, 2'd1, 0, C_NONE,  pa(1, 0));
        send(0, SUB,  0, 2'd2, 1, C_UNDER, pa(1, 0));
        send(0, UNDO, 0, 2'd0, 0, C_NONE,  pa(0, 0));
        send(0, ADD,  0, 2'd1, 0, C_NONE,  pa(1, 0));
        send(0, ADD,  0, 2'd1, 0, C_NONE,  pa(2, 0));
        send(0, SUB,  0, 2'd2, 0, C_NONE,  pa(0, 0));

        // Overflow at MAX_SCORE = 99
        for (int i = 1; i <= 32; i++) send(0, ADD, 1, 2'd3, 0, C_NONE, pa(0, 3 * i));
        send(0, ADD, 1, 2'd2, 0, C_NONE, pa(0, 98));
        send(0, ADD, 1, 2'd3, 1, C_OVER, pa(0, 98));
        send(0, ADD, 1, 2'd1, 0, C_NONE, pa(0, 99));
        send(0, ADD, 1, 2'd1, 1, C_OVER, pa(0, 99));
        settle(5);
        cmp("leader_0_99", 32'(leader_a), 1);
        cmp("tie_0_99", 32'(tie_a), 0);

        // Undo, empty history, zero points, reserved op
        clear_a();
        send(0, ADD,  1, 2'd3, 0, C_NONE, pa(0, 3));
        send(0, ADD,  1, 2'd2, 0, C_NONE, pa(0, 5));
        send(0, ADD,  1, 2'd3, 0, C_NONE, pa(0, 8));
        send(0, UNDO, 0, 2'd0, 0, C_NONE, pa(0, 5));
        send(0, UNDO, 0, 2'd0, 1, C_INV,  pa(0, 5));
        send(0, ADD,  1, 2'd0, 1, C_INV,  pa(0, 5));
        send(0, RSV,  0, 2'd1, 1, C_INV,  pa(0, 5));
        settle(5);
        cmp("rej_code_held", 32'(rej_code_a), 32'(C_INV));
        cmp("rej_low_after_pulse", 32'(rej_a), 0);

        // Clear during CHECK aborts the command without done
        @(negedge clk);
        op    = ADD;
        team  = 2'd1;
        pts   = 2'd1;
        vld_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        cmp("ready_in_check", 32'(rdy_a), 0);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        cmp("ready_after_clear", 32'(rdy_a), 1);
        cmp("score_after_abort", 32'(score_a), 0);
        settle(5);
        send(0, UNDO, 0, 2'd0, 1, C_INV, pa(0, 0));

        // Clear and cmd_valid together in IDLE: command not accepted
        settle(4);
        op    = ADD;
        team  = 2'd0;
        pts   = 2'd1;
        vld_a = 1'b1;
        clr_a = 1'b1;
        @(negedge clk);
        vld_a = 1'b0;
        clr_a = 1'b0;
        cmp("ready_clear_wins", 32'(rdy_a), 1);
        settle(5);
        cmp("score_clear_wins", 32'(score_a), 0);

        // Four-team instance: build 10/30/30/5
        send(1, ADD, 0, 2'd3, 0, C_NONE, pb(3, 0, 0, 0));
        send(1, ADD, 0, 2'd3, 0, C_NONE, pb(6, 0, 0, 0));
        send(1, ADD, 0, 2'd3, 0, C_NONE, pb(9, 0, 0, 0));
        send(1, ADD, 0, 2'd1, 0, C_NONE, pb(10, 0, 0, 0));
        for (int i = 1; i <= 10; i++) send(1, ADD, 1, 2'd3, 0, C_NONE, pb(10, 3 * i, 0, 0));
        for (int i = 1; i <= 10; i++) send(1, ADD, 2, 2'd3, 0, C_NONE, pb(10, 30, 3 * i, 0));
        send(1, ADD, 3, 2'd3, 0, C_NONE, pb(10, 30, 30, 3));
        send(1, ADD, 3, 2'd2, 0, C_NONE, pb(10, 30, 30, 5));
        settle(5);
        cmp("leader_b_tie", 32'(leader_b), 1);
        cmp("tie_b_tie", 32'(tie_b), 1);
        send(1, SUB, 3, 2'd3, 0, C_NONE, pb(10, 30, 30, 2));
        send(1, SUB, 1, 2'd3, 0, C_NONE, pb(10, 27, 30, 2));
        settle(5);
        cmp("leader_b_after_sub", 32'(leader_b), 2);
        cmp("tie_b_after_sub", 32'(tie_b), 0);

        settle(5);
        cmp("pending_a", 32'(qa.size()), 0);
        cmp("pending_b", 32'(qb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
# score_keeper

Parametrised multi-team score register with guarded add/subtract and one-deep undo, for the basketball scoreboard datapath. Accepts one debounced scoring command at a time, checks it against underflow (subtracting more points than held) and overflow (exceeding `MAX_SCORE`), then commits or rejects it. Sits between the button/command decoder and the 7-segment display drivers; it supplies per-team scores plus leader/tie status.

## Interface
- `N_TEAMS`, 2, number of independent score channels (≥2)
- `SCORE_W`, 7, score width in bits
- `MAX_SCORE`, 99, highest legal score (≤ 2**SCORE_W−1)
- `TEAM_W`, $clog2(N_TEAMS), team index width (derived)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `clear`  in  1  synchronous wipe of all scores and undo history
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_op`  in  2  00 ADD, 01 SUB, 10 UNDO, 11 reserved
- `cmd_team`  in  TEAM_W  target team (ignored for UNDO)
- `cmd_pts`  in  2  points 1..3 (ignored for UNDO)
- `score`  out  N_TEAMS*SCORE_W  packed scores, team 0 in LSBs
- `done`  out  1  one-cycle pulse when a command finishes
- `rej`  out  1  with `done`: command rejected, no score changed
- `rej_code`  out  2  00 none, 01 underflow, 10 overflow, 11 invalid
- `leader`  out  TEAM_W  index of highest score, lowest index wins ties
- `tie`  out  1  two or more teams share the highest score

## Operation
- FSM states: IDLE, CHECK, APPLY.
- IDLE: `cmd_ready`=1; `cmd_valid`&`cmd_ready` latches op/team/pts and moves to CHECK.
- CHECK: registers the selected score, the result, and the legality verdict:
  - SUB legal iff `cmd_pts` ≤ score, else underflow (01).
  - ADD legal iff score+`cmd_pts` ≤ `MAX_SCORE`, computed at SCORE_W+1 bits, else overflow (10).
  - `cmd_pts`=0, `cmd_team` ≥ N_TEAMS, op=11, or UNDO with an empty history → invalid (11).
- APPLY: on a legal command, writes the score and pulses `done`; on an illegal command, pulses `done` and `rej` with `rej_code`. Returns to IDLE.
- Undo history is one entry: {valid, team, previous score}.
  - A legal ADD/SUB loads it.
  - A legal UNDO restores the previous score and invalidates the history.
  - A rejected command leaves the history untouched.
- `clear` (priority over everything but reset): all scores set to 0, history invalidated, FSM forced to IDLE. A command in flight is aborted with no `done`.
- `leader` and `tie` are registered from the `score` register and lag score changes by one cycle.

## Timing
- Reset values (`rst_n`=0 at a clock edge): `score`=0, history invalid, FSM IDLE, `cmd_ready`=1, `done`=0, `rej`=0, `rej_code`=00, `leader`=0, `tie`=1.
- A command accepted at edge T produces CHECK at T+1 and APPLY at T+2. `done`, `rej`, and `rej_code` are valid in the cycle after edge T+2, and the new `score` is visible then too.
- `leader` and `tie` update one cycle after the new `score` appears.
- `cmd_ready` is 0 during CHECK and APPLY and returns to 1 in the cycle `done` is high. Throughput is one command per 3 cycles.
- `rej_code` holds its value until the next `done`. `done` and `rej` are single-cycle.
- If `clear` and `cmd_valid` are high in the same IDLE cycle, `clear` wins and the command is not accepted.

## Structure
- Package `score_pkg`: `op_e` (ADD/SUB/UNDO/RSVD), `rej_e` codes, `state_e`, and a score-width localparam helper.
- Sub-module `score_guard` (combinational): inputs current score, op, and pts; outputs next score, legal, and `rej_code`. It is the only place underflow/overflow arithmetic lives, and it is instantiated once in CHECK.
- Leader/tie logic is a linear scan over N_TEAMS in the top level.

## Test plan
- Reset, then ADD team0 pts=3 twice, then ADD team1 pts=2 → scores 6/2, `done` 3 cycles after each accept, `leader`=0, `tie`=0.
- Team0=1, SUB pts=2 → `rej`=1, `rej_code`=01, score stays 1. Team0=2, SUB pts=2 → score 0, no reject.
- Team1=98, ADD pts=3 → overflow 10, score 98. ADD pts=1 → 99. With `MAX_SCORE`=99, ADD pts=1 → overflow.
- ADD team1 pts=3 (5→8), then UNDO → 5. A second UNDO → invalid 11. `cmd_pts`=0 → invalid.
- Assert `clear` in the CHECK cycle of an ADD → no `done`, all scores 0, next cycle `cmd_ready`=1, then UNDO → invalid.
- N_TEAMS=4, SCORE_W=8, MAX_SCORE=200: scores 10/30/30/5 → `leader`=1, `tie`=1; `cmd_team`=4 impossible, `cmd_team`=3 SUB pts=3 → 2.
